// File: rtl/gnn_pkg.sv
// Shared GNN tile definitions: aggregated word geometry and the serializer FSM state.
package gnn_pkg;

  localparam int AGGR_OUT_SIZE = 7;
  localparam int NUM_NODES     = 4;
  localparam int NUM_FEAT      = 4;

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } state_t;

endpackage : gnn_pkg

// File: rtl/aggr_serializer.sv
// Serializes one aggregated 4x4 feature tile into a valid/ready word stream,
// feature-major (k = feat*4 + node), with back-to-back tile chaining and drop detection.
module aggr_serializer #(
  parameter int AGGR_OUT_SIZE = gnn_pkg::AGGR_OUT_SIZE,
  parameter int NUM_NODES     = gnn_pkg::NUM_NODES,
  parameter int NUM_FEAT      = gnn_pkg::NUM_FEAT
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          in_ready_ser,
  input  logic [15:0][AGGR_OUT_SIZE-1:0] agg_in,
  output logic [AGGR_OUT_SIZE-1:0]      out_data,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [1:0]                    out_feat,
  output logic [1:0]                    out_node,
  output logic                          out_last,
  output logic                          busy,
  output logic                          overflow,
  input  logic                          clr_ovf
);

  import gnn_pkg::*;

  localparam int         NUM_WORDS = NUM_NODES * NUM_FEAT;
  localparam logic [3:0] LAST_IDX  = 4'(NUM_WORDS - 1);

  state_t                                   state_q, state_d;
  logic [3:0]                               idx_q, idx_d;
  logic [NUM_WORDS-1:0][AGGR_OUT_SIZE-1:0]  tile_q, tile_d;
  logic                                     ovf_q, ovf_d;
  logic                                     handshake, wrap, drop;

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge values computed by the combinational blocks.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // NOTE: the tile buffer is reset as well, so out_data reads 0 after reset
  // rather than stale data from a previous, aborted tile.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx_q  <= '0;
      tile_q <= '0;
      ovf_q  <= 1'b0;
    end else begin
      idx_q  <= idx_d;
      tile_q <= tile_d;
      ovf_q  <= ovf_d;
    end
  end

  // NOTE: every variable gets a default at the top so no path infers a latch.
  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    tile_d    = tile_q;
    ovf_d     = ovf_q;
    handshake = (state_q == SEND) && out_ready;
    wrap      = handshake && (idx_q == LAST_IDX);
    drop      = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (in_ready_ser) begin
          tile_d  = agg_in;
          idx_d   = '0;
          state_d = SEND;
        end
      end
      SEND: begin
        if (wrap) begin
          // Last word leaving: a coincident strobe chains the next tile with no bubble.
          idx_d = '0;
          if (in_ready_ser) tile_d  = agg_in;
          else              state_d = IDLE;
        end else begin
          if (handshake) idx_d = idx_q + 4'd1;
          drop = in_ready_ser;
        end
      end
      default: state_d = IDLE;
    endcase

    if (drop)         ovf_d = 1'b1;
    else if (clr_ovf) ovf_d = 1'b0;
  end

  always_comb begin
    out_valid = (state_q == SEND);
    busy      = (state_q == SEND);
    out_data  = out_valid ? tile_q[idx_q] : '0;
    out_feat  = idx_q[3:2];
    out_node  = idx_q[1:0];
    out_last  = out_valid && (idx_q == LAST_IDX);
    overflow  = ovf_q;
  end

endmodule : aggr_serializer

// File: tb/tb_aggr_serializer.sv
// Scoreboard bench for aggr_serializer: stimulus pushes expected words, a negedge
// monitor pops and compares on every accepted transfer.
module tb_aggr_serializer;

  localparam int W = 7;

  typedef struct packed {
    logic [W-1:0] data;
    logic [1:0]   feat;
    logic [1:0]   node;
    logic         last;
  } word_t;

  logic                 clk = 1'b0;
  logic                 rst_n = 1'b0;
  logic                 in_ready_ser = 1'b0;
  logic [15:0][W-1:0]   agg_in = '0;
  logic [W-1:0]         out_data;
  logic                 out_valid;
  logic                 out_ready = 1'b1;
  logic [1:0]           out_feat;
  logic [1:0]           out_node;
  logic                 out_last;
  logic                 busy;
  logic                 overflow;
  logic                 clr_ovf = 1'b0;

  int    pass_cnt  = 0;
  int    total_cnt = 0;
  word_t exp_q[$];

  always #5 clk = ~clk;

  aggr_serializer #(.AGGR_OUT_SIZE(W)) dut (
    .clk(clk), .rst_n(rst_n), .in_ready_ser(in_ready_ser), .agg_in(agg_in),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .out_feat(out_feat), .out_node(out_node), .out_last(out_last),
    .busy(busy), .overflow(overflow), .clr_ovf(clr_ovf)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present a tile for one cycle; when 'expect_it' the tile is queued as expected output.
  task automatic strobe(input logic [15:0][W-1:0] tile, input bit expect_it);
    word_t w;
    agg_in       = tile;
    in_ready_ser = 1'b1;
    if (expect_it) begin
      for (int k = 0; k < 16; k++) begin
        logic [3:0] kk;
        kk     = 4'(k);
        w.data = tile[k];
        w.feat = kk[3:2];
        w.node = kk[1:0];
        w.last = (k == 15);
        exp_q.push_back(w);
      end
    end
    tick();
    in_ready_ser = 1'b0;
  endtask

  // Monitor: compares accepted words and checks hold-stability under backpressure.
  word_t prev_w;
  logic  prev_stall = 1'b0;
  always @(negedge clk) begin
    word_t act, exp;
    act = '{data: out_data, feat: out_feat, node: out_node, last: out_last};
    if (!rst_n) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        check("hold_valid", 32'(out_valid), 32'd1);
        check("hold_word", 32'(act), 32'(prev_w));
      end
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          check("unexpected_word", 32'(act), 32'hFFFF_FFFF);
        end else begin
          exp = exp_q.pop_front();
          check("stream_word", 32'(act), 32'(exp));
        end
      end
      prev_stall = out_valid && !out_ready;
      prev_w     = act;
    end
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running, expected finished");
    $fatal(1, "timeout");
  end

  initial begin
    logic [15:0][W-1:0] tile;

    // Reset state
    #12;
    check("rst_valid", 32'(out_valid), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_ovf", 32'(overflow), 32'd0);
    check("rst_data", 32'(out_data), 32'd0);
    check("rst_fn", 32'({out_feat, out_node, out_last}), 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    // Basic tile: words 1..16
    for (int k = 0; k < 16; k++) tile[k] = 7'(k + 1);
    strobe(tile, 1'b1);
    check("first_word", 32'(out_data), 32'd1);
    for (int i = 0; i < 16; i++) tick();
    check("basic_idle_valid", 32'(out_valid), 32'd0);
    check("basic_idle_busy", 32'(busy), 32'd0);

    // Backpressure on word 2 for 5 cycles
    for (int k = 0; k < 16; k++) tile[k] = 7'(k * 3 + 20);
    strobe(tile, 1'b1);
    tick(); tick();
    check("bp_word2", 32'(out_data), 32'd26);
    out_ready = 1'b0;
    for (int i = 0; i < 5; i++) tick();
    out_ready = 1'b1;
    for (int i = 0; i < 14; i++) tick();
    check("bp_idle", 32'(out_valid), 32'd0);

    // Back-to-back tiles, 16 cycles apart
    for (int k = 0; k < 16; k++) tile[k] = 7'(100 - k);
    strobe(tile, 1'b1);
    for (int i = 0; i < 15; i++) begin
      check("b2b_busy_a", 32'(busy), 32'd1);
      tick();
    end
    check("b2b_last_a", 32'(out_last), 32'd1);
    for (int k = 0; k < 16; k++) tile[k] = 7'(k * 5 + 1);
    strobe(tile, 1'b1);
    check("b2b_chain_word0", 32'(out_data), 32'd1);
    for (int i = 0; i < 16; i++) begin
      check("b2b_busy_b", 32'(busy), 32'd1);
      tick();
    end
    check("b2b_ovf", 32'(overflow), 32'd0);
    check("b2b_idle", 32'(out_valid), 32'd0);

    // Drop at idx=6
    for (int k = 0; k < 16; k++) tile[k] = 7'(k + 40);
    strobe(tile, 1'b1);
    for (int i = 0; i < 6; i++) tick();
    check("drop_idx6", 32'({out_feat, out_node}), 32'd6);
    for (int k = 0; k < 16; k++) tile[k] = 7'h55;
    strobe(tile, 1'b0);
    check("drop_ovf_set", 32'(overflow), 32'd1);
    for (int i = 0; i < 9; i++) tick();
    check("drop_idle", 32'(out_valid), 32'd0);
    check("drop_ovf_sticky", 32'(overflow), 32'd1);
    clr_ovf = 1'b1;
    tick();
    clr_ovf = 1'b0;
    check("ovf_cleared", 32'(overflow), 32'd0);

    // Reset at idx=9 aborts the stream
    for (int k = 0; k < 16; k++) tile[k] = 7'(k + 60);
    strobe(tile, 1'b1);
    for (int i = 0; i < 9; i++) tick();
    exp_q.delete();
    rst_n = 1'b0;
    #1;
    check("rst_async_valid", 32'(out_valid), 32'd0);
    check("rst_async_data", 32'(out_data), 32'd0);
    tick(); tick();
    rst_n = 1'b1;
    for (int k = 0; k < 16; k++) tile[k] = 7'(7'h7F - k);
    strobe(tile, 1'b1);
    check("post_rst_word0", 32'(out_data), 32'd127);
    for (int i = 0; i < 16; i++) tick();

    // All-ones width check
    for (int k = 0; k < 16; k++) tile[k] = 7'h7F;
    strobe(tile, 1'b1);
    for (int i = 0; i < 16; i++) tick();
    check("final_idle", 32'(out_valid), 32'd0);
    check("queue_drained", 32'(exp_q.size()), 32'd0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule : tb_aggr_serializer
